// File: rtl/serializer_pkg.sv
// Shared definitions for the sample-memory serializer/deserializer pair:
// the serializer state encoding and the default sample-buffer geometry.
package serializer_pkg;

    // Playback sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } ser_state_e;

    // Default sample buffer geometry and bit timing (1 MHz from 100 MHz).
    localparam int SAMPLE_DEPTH  = 62500;
    localparam int SAMPLE_ADDR_W = 16;
    localparam int BIT_CLK_DIV   = 100;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled and raises tick for
// the single cycle in which the count sits at CLK_DIV-1. A synchronous clear
// realigns the period to a frame start. CLK_DIV must be 2 or more.
module bit_tick_gen
    import serializer_pkg::*;
#(
    parameter int CLK_DIV = BIT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise wrap at the end of each bit period.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // the pre-edge value of every other register.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_read_serializer.sv
// Playback serializer: walks the sample RAM from address 0 to DEPTH-1
// (wrapping), issues one read per word and shifts each word out MSB-first,
// each bit held CLK_DIV clocks.
// Optional build macro SERIALIZER_PARITY_EN appends one even-parity bit
// period after the payload, inside frame.
module mem_read_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = SAMPLE_ADDR_W,
    parameter int DEPTH   = SAMPLE_DEPTH,
    parameter int CLK_DIV = BIT_CLK_DIV
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              serial_out,
    output logic              frame,
    output logic              word_done,
    output logic              pass_done,
    output logic              busy
);

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    ser_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] load_word;
    logic               bit_tick;

    // Frame image loaded from the RAM: payload, then parity when enabled.
`ifdef SERIALIZER_PARITY_EN
    assign load_word = {mem_rdata, ^mem_rdata};
`else
    assign load_word = mem_rdata;
`endif

    // Bit-period timing, realigned to zero while the read data is returning.
    bit_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_tick (
        .clk   (clock),
        .rst_n (reset),
        .clr   (state_q == WAIT),
        .en    (state_q == SHIFT),
        .tick  (bit_tick)
    );

    // Moore outputs decoded straight from state so reset clears them at once.
    assign mem_addr   = addr_q;
    assign mem_rd_en  = (state_q == FETCH);
    assign frame      = (state_q == SHIFT);
    assign serial_out = (state_q == SHIFT) && shift_q[FRAME_W-1];
    assign busy       = (state_q != IDLE);

    // Next-state, datapath and end-of-word pulse logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        word_done = 1'b0;
        pass_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = FETCH;
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                shift_d   = load_word;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (bit_tick) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        word_done = 1'b1;
                        // Wrap on the configured depth, not on address overflow.
                        if (addr_q == ADDR_LAST) begin
                            addr_d    = '0;
                            pass_done = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                        state_d = enable ? FETCH : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_read_serializer.sv
// Bench for mem_read_serializer: two instances (CLK_DIV=4 and CLK_DIV=2)
// share enable/reset and a 4-word sample RAM. A cycle-offset model predicts
// every output each cycle; frame captures and directed literals pin it.
module tb_mem_read_serializer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
    localparam int AW_MEM = 2;
    localparam int NI     = 2;

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
    localparam logic [FRAME_W-1:0] FRAME_A5 = 9'h14A;
    localparam logic [FRAME_W-1:0] FRAME_3C = 9'h078;
    localparam logic [FRAME_W-1:0] FRAME_07 = 9'h00F;
`else
    localparam int FRAME_W = DATA_W;
    localparam logic [FRAME_W-1:0] FRAME_A5 = 8'hA5;
    localparam logic [FRAME_W-1:0] FRAME_3C = 8'h3C;
    localparam logic [FRAME_W-1:0] FRAME_07 = 8'h07;
`endif

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;

    logic [ADDR_W-1:0] mem_addr [NI];
    logic              rd_en    [NI];
    logic [DATA_W-1:0] rdata    [NI];
    logic              serial   [NI];
    logic              frame    [NI];
    logic              wdone    [NI];
    logic              pdone    [NI];
    logic              busy     [NI];

    logic [DATA_W-1:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_read_serializer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLK_DIV(4)) dut_div4 (
        .clock(clock), .reset(reset), .enable(enable),
        .mem_addr(mem_addr[0]), .mem_rd_en(rd_en[0]), .mem_rdata(rdata[0]),
        .serial_out(serial[0]), .frame(frame[0]), .word_done(wdone[0]),
        .pass_done(pdone[0]), .busy(busy[0])
    );

    mem_read_serializer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLK_DIV(2)) dut_div2 (
        .clock(clock), .reset(reset), .enable(enable),
        .mem_addr(mem_addr[1]), .mem_rd_en(rd_en[1]), .mem_rdata(rdata[1]),
        .serial_out(serial[1]), .frame(frame[1]), .word_done(wdone[1]),
        .pass_done(pdone[1]), .busy(busy[1])
    );

    // Synchronous-read sample RAM: data valid the cycle after the strobe.
    always @(posedge clock) begin
        if (rd_en[0] == 1'b1) rdata[0] <= mem[mem_addr[0][AW_MEM-1:0]];
        if (rd_en[1] == 1'b1) rdata[1] <= mem[mem_addr[1][AW_MEM-1:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    // One word occupies FETCH + WAIT + FRAME_W bit periods.
    function automatic int word_len(input int i);
        return 2 + FRAME_W * div_of(i);
    endfunction

    function automatic logic frame_bit(input logic [DATA_W-1:0] w, input int idx);
        if (idx < DATA_W) return w[DATA_W-1-idx];
        return ^w;
    endfunction

    // ---------------- behavioural model ----------------
    // Per instance: busy flag, cycle offset within the current word, address.
    logic m_busy [NI];
    int   m_k    [NI];
    int   m_addr [NI];

    always @(posedge clock or negedge reset) begin
        for (int i = 0; i < NI; i++) begin
            if (!reset) begin
                m_busy[i] <= 1'b0;
                m_k[i]    <= 0;
                m_addr[i] <= 0;
            end else if (!m_busy[i]) begin
                if (enable) begin
                    m_busy[i] <= 1'b1;
                    m_k[i]    <= 0;
                end
            end else if (m_k[i] == word_len(i) - 1) begin
                m_addr[i] <= (m_addr[i] + 1) % DEPTH;
                if (enable) m_k[i] <= 0;
                else        m_busy[i] <= 1'b0;
            end else begin
                m_k[i] <= m_k[i] + 1;
            end
        end
    end

    function automatic logic [31:0] expect_out(input int i);
        logic rd, ser, fr, wd, pd, bz;
        int   k;
        rd = 1'b0; ser = 1'b0; fr = 1'b0; wd = 1'b0; pd = 1'b0; bz = 1'b0;
        if (m_busy[i]) begin
            k  = m_k[i];
            bz = 1'b1;
            rd = (k == 0);
            fr = (k >= 2);
            if (fr) ser = frame_bit(mem[m_addr[i][AW_MEM-1:0]], (k - 2) / div_of(i));
            wd = (k == word_len(i) - 1);
            pd = wd && (m_addr[i] == DEPTH - 1);
        end
        return 32'({ADDR_W'(m_addr[i]), rd, ser, fr, wd, pd, bz});
    endfunction

    function automatic logic [31:0] actual_out(input int i);
        return 32'({mem_addr[i], rd_en[i], serial[i], frame[i], wdone[i], pdone[i], busy[i]});
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        for (int i = 0; i < NI; i++)
            check((i == 0) ? "cycle_div4" : "cycle_div2", actual_out(i), expect_out(i));
    end

    // ---------------- frame capture ----------------
    logic                cap [NI][$];
    logic [FRAME_W-1:0]  last_frame [NI];
    int                  words_seen [NI] = '{0, 0};
    int                  pdone_cnt  [NI] = '{0, 0};
    logic [ADDR_W-1:0]   addr_log [$];

    function automatic logic [FRAME_W-1:0] decode_frame(input int i);
        logic [FRAME_W-1:0] fb;
        fb = '0;
        for (int j = 0; j < FRAME_W; j++) fb[FRAME_W-1-j] = cap[i][j * div_of(i)];
        return fb;
    endfunction

    function automatic logic frame_held(input int i);
        for (int j = 0; j < FRAME_W; j++)
            for (int r = 1; r < div_of(i); r++)
                if (cap[i][j * div_of(i) + r] !== cap[i][j * div_of(i)]) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clock) begin
        for (int i = 0; i < NI; i++) begin
            if (!reset) begin
                cap[i].delete();
            end else begin
                if (frame[i] == 1'b1) cap[i].push_back(serial[i]);
                if (pdone[i] == 1'b1) pdone_cnt[i] <= pdone_cnt[i] + 1;
                if (wdone[i] == 1'b1) begin
                    check((i == 0) ? "frame_len_div4" : "frame_len_div2",
                          32'(cap[i].size()), 32'(FRAME_W * div_of(i)));
                    if (cap[i].size() == FRAME_W * div_of(i)) begin
                        check((i == 0) ? "bit_hold_div4" : "bit_hold_div2", 32'(frame_held(i)), 32'd1);
                        if (words_seen[i] == 0)
                            check((i == 0) ? "first_word_div4" : "first_word_div2",
                                  32'(decode_frame(i)), 32'(FRAME_A5));
                        last_frame[i] <= decode_frame(i);
                    end
                    words_seen[i] <= words_seen[i] + 1;
                    cap[i].delete();
                end
            end
        end
        if (reset && rd_en[0] == 1'b1) addr_log.push_back(mem_addr[0]);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic cond_met(input int kind, input int arg);
        case (kind)
            0:       return rd_en[0] == 1'b1 && mem_addr[0] == ADDR_W'(arg);
            1:       return busy[0] == 1'b0;
            2:       return wdone[0] == 1'b1;
            3:       return addr_log.size() >= arg;
            default: return rd_en[0] == 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int kind, input int arg, input int limit, input string name);
        int n;
        n = 0;
        while (!cond_met(kind, arg) && n < limit) begin
            tick(1);
            n++;
        end
        check(name, 32'(cond_met(kind, arg)), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h00;
        enable = 1'b0;
        reset  = 1'b0;
        tick(3);
        check("reset_outputs", actual_out(0), 32'd0);
        reset = 1'b1;
        tick(2);

        // Latency from enable to read strobe and first bit.
        enable = 1'b1;
        tick(1);
        check("rd_en_latency", 32'(rd_en[0]), 32'd1);
        check("fetch_addr0", 32'(mem_addr[0]), 32'd0);
        tick(1);
        check("rd_en_one_cycle", 32'(rd_en[0]), 32'd0);
        tick(1);
        check("first_bit", 32'({frame[0], serial[0]}), 32'b11);

        // One full pass plus the wrap fetch.
        wait_for(3, 5, 400, "pass_timeout_ok");
        check("addr_seq0", 32'(addr_log[0]), 32'd0);
        check("addr_seq1", 32'(addr_log[1]), 32'd1);
        check("addr_seq2", 32'(addr_log[2]), 32'd2);
        check("addr_seq3", 32'(addr_log[3]), 32'd3);
        check("addr_seq4", 32'(addr_log[4]), 32'd0);
        check("pass_done_count", 32'(pdone_cnt[0]), 32'd1);

        // Drop enable during bit 3 of the word at address 1.
        wait_for(0, 1, 200, "fetch_addr1_ok");
        tick(14);
        enable = 1'b0;
        wait_for(1, 0, 100, "idle_after_drop_ok");
        check("addr_after_drop", 32'(mem_addr[0]), 32'd2);
        check("dropped_word_complete", 32'(last_frame[0]), 32'(FRAME_3C));
        tick(5);
        enable = 1'b1;
        wait_for(4, 0, 20, "resume_fetch_ok");
        check("resume_addr", 32'(mem_addr[0]), 32'd2);

        // Asynchronous reset in the middle of the word at address 2.
        tick(10);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", actual_out(0), 32'd0);
        mem[0] = 8'h07;
        tick(3);
        reset = 1'b1;
        wait_for(4, 0, 10, "restart_fetch_ok");
        check("restart_addr0", 32'(mem_addr[0]), 32'd0);
        wait_for(2, 0, 60, "word07_done_ok");
        tick(1);
        check("word07_frame", 32'(last_frame[0]), 32'(FRAME_07));

        // Randomized enable patterns, fresh RAM contents per round, occasional
        // asynchronous reset pulses.
        for (int round = 0; round < 6; round++) begin
            reset = 1'b0;
            for (int j = 0; j < DEPTH; j++) mem[j] = DATA_W'($urandom);
            tick(2);
            reset = 1'b1;
            for (int n = 0; n < 30; n++) begin
                enable = ($urandom_range(0, 3) != 0);
                tick($urandom_range(1, 40));
                if ($urandom_range(0, 9) == 0) begin
                    #3 reset = 1'b0;
                    #2 reset = 1'b1;
                    tick(1);
                end
            end
        end

        enable = 1'b0;
        tick(100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_read_serializer.md
Name: mem_read_serializer

Overview:
- Playback-side counterpart of the deserializer write path. It walks the sample memory from address 0 to DEPTH-1 and issues one read per word.
- Each returned word is shifted out MSB-first on a single serial line at clock/CLK_DIV bit rate (1 MHz from 100 MHz by default).
- It sits between the sample RAM read port and the serial output pin.

Parameters:
- DATA_W, 8, width of one memory word / serial frame payload.
- ADDR_W, 16, memory address width.
- DEPTH, 62500, number of words; addresses run 0..DEPTH-1 and then wrap.
- CLK_DIV, 100, clock cycles per serial bit; legal range is 2 or more.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  level; high requests continuous streaming.
- mem_addr  out  ADDR_W  read address, registered.
- mem_rd_en  out  1  read strobe, high for exactly one cycle per word.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd_en.
- serial_out  out  1  serial data, MSB first; 0 when not shifting.
- frame  out  1  high while payload (and parity, if enabled) bits are on serial_out.
- word_done  out  1  one-cycle pulse when the last bit period of a word ends.
- pass_done  out  1  one-cycle pulse coincident with word_done for address DEPTH-1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; mem_addr=0, shift register=0, bit counter=0, divider=0.
  - All outputs are 0.
  - Reset mid-word aborts immediately. The next pass restarts at address 0.
- States: IDLE, FETCH, WAIT, SHIFT.
- IDLE -> FETCH when enable=1 on a clock edge.
- FETCH: mem_rd_en=1 for this one cycle; mem_addr is held. Next state is WAIT.
- WAIT:
  - mem_rdata is valid during this cycle.
  - At the clock edge: shift_reg<=mem_rdata, bit counter<=0, divider<=0, state<=SHIFT.
- SHIFT:
  - serial_out=shift_reg[DATA_W-1]; frame=1.
  - Divider counts 0..CLK_DIV-1. At CLK_DIV-1 it shifts left by 1 and increments the bit counter.
  - Each bit is held exactly CLK_DIV cycles.
  - After the last bit's period:
    - word_done pulses.
    - mem_addr increments; if mem_addr was DEPTH-1 it wraps to 0 and pass_done pulses in the same cycle.
    - Next state is FETCH if enable=1, else IDLE.
- Latency: enable rising in IDLE at edge N gives mem_rd_en at cycle N+1, with the first bit on serial_out from cycle N+3.
- Inter-word gap is 2 cycles (FETCH, WAIT) with frame=0 and serial_out=0.
- enable deasserted mid-word: the current word always completes, the address still advances, then the block goes to IDLE. mem_addr is retained, so re-enabling resumes at the next word.
- enable toggling in FETCH/WAIT is ignored; it is sampled only in IDLE and at the end of SHIFT.
- Address arithmetic is ADDR_W bits. The wrap compare is against DEPTH-1, never against natural overflow.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - One extra bit period follows the payload, carrying even parity (XOR of all DATA_W payload bits), with frame=1.
  - A word frame is DATA_W+1 bits; word_done fires at the end of the parity bit.
- Undefined: frame is exactly DATA_W bits and no parity logic is present.

Decomposition:
- Package serializer_pkg:
  - state enum type (IDLE, FETCH, WAIT, SHIFT).
  - default constants SAMPLE_DEPTH=62500, SAMPLE_ADDR_W=16, BIT_CLK_DIV=100, shared with the deserializer address logic.
- Sub-module bit_tick_gen: CLK_DIV divider with synchronous clear input and a one-cycle tick output. It is reusable by the deserializer for bit sampling.

Test Plan (DATA_W=8, DEPTH=4, CLK_DIV=4):
- Reset then enable=1 with memory {0xA5,0x3C,0xFF,0x00}:
  - mem_rd_en 1 cycle after enable.
  - serial_out 1,0,1,0,0,1,0,1, each bit held 4 cycles.
  - word_done after 32 SHIFT cycles.
- Continuous enable over 4 words:
  - mem_addr sequence is 0,1,2,3,0.
  - pass_done pulses once, coincident with word_done of address 3.
  - 2-cycle gap between frames.
- Drop enable at bit 3 of word at address 1:
  - All 8 bits are emitted, mem_addr=2, then IDLE with busy=0.
  - Re-enable: the next fetch is at address 2.
- Assert reset=0 mid-SHIFT of address 2:
  - serial_out, frame and busy drop to 0 immediately and mem_addr=0.
  - After release and enable, the fetch is at address 0.
- With SERIALIZER_PARITY_EN and word 0xA5: a 9th bit of 0 follows the payload with frame=1. For 0x07 the 9th bit is 1.
- CLK_DIV=2 boundary: every bit is held exactly 2 cycles and there is no extra or missing bit.
